// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Pure definitions: no logic, no latency, no flow control.
package imem_loader_pkg;

  localparam int          DEFAULT_ADDR_W = 10;
  // Byte address of word index 0 in the CPU's view of instruction memory.
  localparam logic [31:0] IMEM_BASE      = 32'h0000_3000;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs a byte stream big-endian into 32-bit words; word_vld pulses one cycle after the 4th byte.
// No backpressure: every byte_vld is taken, clear restarts packing at byte 0.
module word_packer (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [23:0] sh;
  logic [1:0]  cnt;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sh       <= '0;
      cnt      <= '0;
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= 1'b0;
      if (clear) begin
        sh  <= '0;
        cnt <= '0;
      end else if (byte_vld) begin
        sh  <= {sh[15:0], byte_dat};
        cnt <= cnt + 2'd1;
        // word_dat only changes on completion so it holds between writes
        if (cnt == 2'd3) begin
          word_vld <= 1'b1;
          word_dat <= {sh, byte_dat};
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: length-prefixed byte image -> one-cycle imem word writes, CPU held until checksum matches.
// Writes land one cycle after a word's 4th byte; in_ready is high only while a load is in progress.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int MAX_WORDS = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_written
);

  state_t      state, state_nxt;
  logic [7:0]  len_hi;
  logic [7:0]  cksum;
  logic [15:0] n_words;
  logic [15:0] len_n;
  logic [1:0]  byte_cnt;
  logic [16:0] wr_next;
  logic        take, load_start, data_take, word_end, last_word, too_long;

  assign take       = in_valid & in_ready;
  assign load_start = start & (state == IDLE || state == DONE || state == ERR);
  assign data_take  = take & (state == DATA);
  assign word_end   = data_take & (byte_cnt == 2'd3);
  assign wr_next    = 17'(words_written) + 17'd1;
  assign last_word  = word_end & (wr_next == {1'b0, n_words});
  assign len_n      = {len_hi, in_data};
  assign too_long   = 32'(len_n) > 32'(MAX_WORDS);

  assign in_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CHK);
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (load_start) state_nxt = LEN_HI;
      LEN_HI: if (take) state_nxt = LEN_LO;
      LEN_LO: if (take) begin
        if (too_long)           state_nxt = ERR;
        else if (len_n == 16'd0) state_nxt = CHK;
        else                    state_nxt = DATA;
      end
      // the final word's write is issued while already in CHK
      DATA:   if (last_word) state_nxt = CHK;
      CHK:    if (take) state_nxt = (in_data == cksum) ? DONE : ERR;
      DONE:   if (load_start) state_nxt = LEN_HI;
      ERR:    if (load_start) state_nxt = LEN_HI;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      len_hi        <= '0;
      n_words       <= '0;
      cksum         <= '0;
      byte_cnt      <= '0;
      words_written <= '0;
      waddr         <= '0;
    end else if (load_start) begin
      cksum         <= '0;
      byte_cnt      <= '0;
      words_written <= '0;
    end else begin
      if (take && state == LEN_HI) len_hi  <= in_data;
      if (take && state == LEN_LO) n_words <= len_n;
      if (data_take) begin
        cksum    <= cksum ^ in_data;
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (word_end) begin
        waddr         <= words_written[ADDR_W-1:0];
        words_written <= words_written + {{ADDR_W{1'b0}}, 1'b1};
      end
    end
  end

  word_packer u_packer (
    .clk      (clk),
    .clr_n    (clr_n),
    .clear    (load_start),
    .byte_vld (data_take),
    .byte_dat (in_data),
    .word_vld (we),
    .word_dat (wdata)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against an image-level reference model.
module tb_imem_loader;

  localparam int AW   = 10;
  localparam int MAXW = 1 << AW;

  logic          clk = 1'b0;
  logic          clr_n, start, in_valid;
  logic [7:0]    in_data;
  logic          in_ready, we, cpu_hold, done, err;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [AW:0]   words_written;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .cpu_hold(cpu_hold),
    .done(done), .err(err), .words_written(words_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // observed write log
  int          wa_q[$];
  logic [31:0] wd_q[$];
  int          dbl_we = 0;
  logic        prev_we = 1'b0;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(int'(waddr));
      wd_q.push_back(wdata);
      if (prev_we === 1'b1) dbl_we++;
    end
    prev_we = we;
  end

  logic [7:0] img[$];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // gap: 0 back-to-back, 1 idle cycle before every byte, 2 random idle cycles
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    logic r;
    ok = 1'b0;
    if (gap == 1) begin
      in_valid = 1'b0;
      tick(1);
    end else if (gap == 2 && $urandom_range(3) == 0) begin
      in_valid = 1'b0;
      tick($urandom_range(1, 3));
    end
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      r = in_ready;
      tick(1);
      if (r === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference: parse img per the image format and predict writes and final status.
  task automatic run_image(input string nm, input int gap);
    int          n, nsend, exp_ww;
    logic [7:0]  x;
    logic [31:0] exp_wd[$];
    bit          exp_done, exp_err, ok;
    n = (int'(img[0]) << 8) | int'(img[1]);
    exp_wd.delete();
    x = 8'h00;
    if (n > MAXW) begin
      nsend = 2; exp_done = 0; exp_err = 1; exp_ww = 0;
    end else begin
      nsend = 2 + 4 * n + 1;
      for (int w = 0; w < n; w++) begin
        exp_wd.push_back({img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]});
        for (int k = 0; k < 4; k++) x = x ^ img[2+4*w+k];
      end
      exp_done = (img[nsend-1] == x);
      exp_err  = !exp_done;
      exp_ww   = n;
    end
    wa_q.delete();
    wd_q.delete();
    pulse_start();
    for (int i = 0; i < nsend; i++) begin
      send_byte(img[i], gap, ok);
      if (!ok) begin
        chk({nm, "/byte_timeout"}, 64'(i), 64'(-1));
        break;
      end
    end
    tick(2);
    chk({nm, "/done"},     64'(done),          64'(exp_done));
    chk({nm, "/err"},      64'(err),           64'(exp_err));
    chk({nm, "/cpu_hold"}, 64'(cpu_hold),      64'(!exp_done));
    chk({nm, "/in_ready"}, 64'(in_ready),      64'(0));
    chk({nm, "/words"},    64'(words_written), 64'(exp_ww));
    chk({nm, "/nwrites"},  64'(wa_q.size()),   64'(exp_wd.size()));
    for (int i = 0; i < exp_wd.size() && i < wa_q.size(); i++) begin
      chk({nm, "/waddr"}, 64'(wa_q[i]), 64'(i));
      chk({nm, "/wdata"}, 64'(wd_q[i]), 64'(exp_wd[i]));
    end
  endtask

  task automatic load_scen1(input logic [7:0] ck);
    img = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C, ck};
  endtask

  initial begin
    bit ok;
    int rdy_cnt, n;
    clr_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #12;
    chk("rst/in_ready", 64'(in_ready), 64'(0));
    chk("rst/we",       64'(we),       64'(0));
    chk("rst/waddr",    64'(waddr),    64'(0));
    chk("rst/wdata",    64'(wdata),    64'(0));
    chk("rst/cpu_hold", 64'(cpu_hold), 64'(1));
    chk("rst/done",     64'(done),     64'(0));
    chk("rst/err",      64'(err),      64'(0));
    chk("rst/words",    64'(words_written), 64'(0));
    @(negedge clk); clr_n = 1'b1;
    tick(1);

    // valid held while idle: nothing may be consumed
    in_valid = 1'b1; in_data = 8'hAA; rdy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (in_ready !== 1'b0) rdy_cnt++;
    end
    tick(1);
    chk("idle/in_ready_cycles", 64'(rdy_cnt), 64'(0));
    load_scen1(8'h2C); run_image("idle_hold", 1);

    load_scen1(8'h2C); run_image("scen1", 0);
    load_scen1(8'h2D); run_image("bad_cksum", 0);
    img = '{8'h04, 8'h01}; run_image("too_long", 0);
    img = '{8'h00, 8'h00, 8'h00}; run_image("empty_ok", 0);
    img = '{8'h00, 8'h00, 8'h01}; run_image("empty_bad", 0);

    // reset after 6 data bytes: one write already issued, then clean reload
    wa_q.delete(); wd_q.delete();
    load_scen1(8'h2C);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(img[i], 0, ok);
    #2 clr_n = 1'b0;
    #1;
    chk("abort/cpu_hold", 64'(cpu_hold), 64'(1));
    chk("abort/in_ready", 64'(in_ready), 64'(0));
    chk("abort/words",    64'(words_written), 64'(0));
    chk("abort/nwrites",  64'(wa_q.size()), 64'(1));
    if (wa_q.size() > 0) begin
      chk("abort/waddr", 64'(wa_q[0]), 64'(0));
      chk("abort/wdata", 64'(wd_q[0]), 64'(32'h24010005));
    end
    @(negedge clk); clr_n = 1'b1;
    tick(1);
    run_image("reload", 0);

    // largest legal image
    img = '{8'h04, 8'h00};
    begin
      logic [7:0] x, b;
      x = 8'h00;
      for (int i = 0; i < 4 * MAXW; i++) begin
        b = 8'($urandom); img.push_back(b); x = x ^ b;
      end
      img.push_back(x);
    end
    run_image("max_len", 0);

    // random short images, random gaps, occasional corrupted checksum
    for (int r = 0; r < 10; r++) begin
      logic [7:0] x, b;
      n = $urandom_range(1, 12);
      img = '{8'h00, 8'(n)};
      x = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        b = 8'($urandom); img.push_back(b); x = x ^ b;
      end
      if ($urandom_range(3) == 0) x = x ^ 8'(1 << $urandom_range(7));
      img.push_back(x);
      run_image("random", 2);
    end

    chk("we_back_to_back", 64'(dbl_we), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: the fetch unit only reads instruction words, and this block fills them.
- Receives a boot image as a byte stream (valid/ready), packs big-endian 32-bit words, and issues one-cycle word writes into instruction memory starting at word index 0 (byte address 0x00003000).
- Holds the CPU via cpu_hold, which drives the fetch unit's clr, until the image is loaded and its checksum is verified.

Parameters:
- ADDR_W, 10, word-index width of instruction memory (1024 words).
- MAX_WORDS, 1<<ADDR_W, largest accepted image length in words.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  reset, asynchronous, active-low.
- start  input  1  single-cycle pulse; begins a load when idle, done or in error.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid&in_ready at the rising edge.
- we  output  1  instruction-memory write strobe, one cycle per word.
- waddr  output  ADDR_W  word index for the write.
- wdata  output  32  word for the write.
- cpu_hold  output  1  keep CPU/fetch unit in reset.
- done  output  1  image loaded and checksum matched (level).
- err  output  1  length or checksum error (level).
- words_written  output  ADDR_W+1  count of words written in the current load.

Behaviour:
- Reset (clr_n low, asynchronous): state IDLE, in_ready=0, we=0, waddr=0, wdata=0, cpu_hold=1, done=0, err=0, words_written=0. Internal byte counter and checksum are cleared. Memory contents are untouched.
- Image format:
  - LEN_HI, LEN_LO: 16-bit word count N, big-endian.
  - N*4 data bytes: first byte of each word lands in wdata[31:24].
  - One checksum byte: XOR of all data bytes. Length bytes are excluded. N=0 expects 0x00.
- States and transitions:
  - IDLE: in_ready=0; start -> LEN_HI.
  - LEN_HI: in_ready=1; on byte, latch the high byte -> LEN_LO.
  - LEN_LO: in_ready=1; on byte, form N.
    - N > MAX_WORDS -> ERR.
    - N = 0 -> CHK.
    - otherwise -> DATA.
  - DATA: in_ready=1; bytes are shifted into a 32-bit assembler and XORed into the checksum.
    - On the 4th byte of a word, the next cycle has we=1 with wdata equal to the packed word and waddr equal to the current word index. words_written increments in that same cycle.
    - After word N-1's 4th byte -> CHK.
  - CHK: in_ready=1; on byte, matches the running XOR -> DONE, else -> ERR.
  - DONE: done=1, cpu_hold=0, in_ready=0; start -> LEN_HI.
  - ERR: err=1, cpu_hold=1, in_ready=0; start -> LEN_HI.
- Transition into LEN_HI clears done, err, words_written, checksum and byte counter, and sets cpu_hold=1.
- start outside IDLE/DONE/ERR is ignored (no abort mid-load).
- in_valid without in_ready is ignored. Bytes are consumed at most one per cycle, so back-to-back bytes are legal.
- we is registered: asserted exactly one cycle, never two consecutive cycles. The minimum gap is 4 cycles.
- waddr and wdata hold their last values when we=0.
- Final-word write vs CHK byte: the write for the final word is issued in the cycle the state is CHK. It completes before any DONE transition, because the checksum byte arrives at the earliest in the same cycle, and DONE appears one cycle later.
- Word index wraps never: N ≤ MAX_WORDS guarantees waddr ≤ MAX_WORDS-1.
- cpu_hold deasserts in the cycle done rises.
- Reset mid-load aborts immediately to IDLE with cpu_hold=1. Partial writes already issued remain in memory.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERR;
  - IMEM_BASE = 32'h00003000 (documentation/debug);
  - default ADDR_W.
- One natural sub-module: word_packer.
  - Inputs: byte + strobe.
  - Function: shifts 4 bytes big-endian and pulses word_valid with the word.
  - Reset by clr_n and a sync clear on load start.

Test Plan:
- Reset then start, stream 00 02 | 24 01 00 05 | 00 00 00 0C | chk=0x2C (XOR of data bytes) -> we pulses twice: waddr 0 wdata 0x24010005, waddr 1 wdata 0x0000000C. Then done=1, cpu_hold=0, words_written=2.
- Same image with checksum byte 0x2D -> err=1, done=0, cpu_hold stays 1, both writes still issued.
- Length 04 01 (1025 > 1024) -> ERR right after LEN_LO, no we pulse, in_ready=0.
- Length 00 00 then checksum 00 -> DONE with zero writes; checksum 01 -> ERR.
- Bytes with in_valid toggling every other cycle, plus in_valid held while in_ready=0 in IDLE -> identical writes to scenario 1, and no byte is consumed in IDLE.
- clr_n low after 6 data bytes, then release and reload the scenario 1 image -> immediate IDLE/cpu_hold=1 on reset, one write at waddr 0 before the abort, and a clean second load ending in done=1.
